spmv_fp16_row_acc: RTL and testbench

// - Downstream of the FP16 multiplier: accumulates the FP16 products of one sparse-matrix row into a running FP16 sum.
// - Emits the row result with its row index over a valid/ready handshake.
// - Sequential FP16 adder: multi-cycle FSM, one product in flight at a time.

---
 rtl/spmv_fp16_row_acc_if.sv | 22 ++
 rtl/spmv_fp16_row_acc.sv | 178 +++++++++++++++++
 tb/tb_spmv_fp16_row_acc.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spmv_fp16_row_acc_if.sv
// Handshake bundle between the FP16 product source, the row accumulator and the row-result consumer.
interface spmv_fp16_row_acc_if #(
    parameter int ROW_W = 8
);
    logic             i_prod_valid;
    logic [15:0]      i_prod;
    logic             i_row_last;
    logic             o_prod_ready;
    logic             o_row_valid;
    logic [15:0]      o_row_sum;
    logic [ROW_W-1:0] o_row_idx;
    logic             i_row_ready;

    modport master (
        output i_prod_valid, i_prod, i_row_last, i_row_ready,
        input  o_prod_ready, o_row_valid, o_row_sum, o_row_idx
    );
    modport slave (
        input  i_prod_valid, i_prod, i_row_last, i_row_ready,
        output o_prod_ready, o_row_valid, o_row_sum, o_row_idx
    );
endinterface

// File: rtl/spmv_fp16_row_acc.sv
// Sequential FP16 row accumulator for SpMV: IDLE/ALIGN/ADD/NORM/OUT, one product in flight.
// Optional feature: define SPMV_ACC_SAT_EN to saturate overflow to max finite instead of infinity.
module spmv_fp16_row_acc #(
    parameter int ROW_W    = 8,
    parameter int NUM_ROWS = 256
) (
    input  logic               i_clk,
    input  logic               i_rst,
    spmv_fp16_row_acc_if.slave bus
);
    typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADD, S_NORM, S_OUT} state_t;

    state_t           state, state_nxt;
    logic [15:0]      acc;
    logic [ROW_W-1:0] row_idx;

    logic [15:0] prod_p0;
    logic        last_p0;

    logic        sgn_big_p1, sgn_sml_p1, spc_p1;
    logic [4:0]  exp_p1;
    logic [13:0] man_big_p1, man_sml_p1;
    logic [15:0] spc_val_p1;

    logic        sgn_p2, spc_p2;
    logic [4:0]  exp_p2;
    logic [14:0] sum_p2;
    logic [15:0] spc_val_p2;

    logic               a_big, sgn_add;
    logic [4:0]         exp_diff;
    logic [13:0]        man_a, man_b, norm_man;
    logic [16:0]        spc;
    logic [14:0]        sum_add;
    logic [3:0]         norm_lz;
    logic signed [6:0]  norm_exp;
    logic [15:0]        norm_res;

    function automatic logic [13:0] ext_man(input logic [15:0] f);
        return (f[14:10] == 5'd0) ? 14'd0 : {1'b1, f[9:0], 3'b000};
    endfunction

    function automatic logic [15:0] clamp_in(input logic [15:0] f);
`ifdef SPMV_ACC_SAT_EN
        return (f[14:10] == 5'h1f) ? {f[15], 15'h7bff} : f;
`else
        return f;
`endif
    endfunction

    function automatic logic [15:0] ovf_res(input logic s);
`ifdef SPMV_ACC_SAT_EN
        return {s, 15'h7bff};
`else
        return {s, 15'h7c00};
`endif
    endfunction

    // {hit, value}: infinity/NaN results bypass the mantissa datapath
    function automatic logic [16:0] inf_res(input logic [15:0] a, input logic [15:0] b);
        logic a_inf, b_inf;
        a_inf = (a[14:10] == 5'h1f);
        b_inf = (b[14:10] == 5'h1f);
        if (a_inf && (a[9:0] != 10'd0)) return {1'b1, a};
        if (a_inf && b_inf && (a[15] != b[15])) return {1'b1, 16'h7e00};
        if (a_inf) return {1'b1, a};
        if (b_inf) return {1'b1, b[15], 15'h7c00};
        return 17'd0;
    endfunction

    // ALIGN: pick the larger exponent, shift the other significand down
    always_comb begin
        a_big    = (acc[14:10] >= prod_p0[14:10]);
        exp_diff = a_big ? (acc[14:10] - prod_p0[14:10]) : (prod_p0[14:10] - acc[14:10]);
        man_a    = ext_man(acc);
        man_b    = ext_man(prod_p0);
        spc      = inf_res(acc, prod_p0);
    end

    // ADD: signed-magnitude add; cancellation always yields +0
    always_comb begin
        sgn_add = sgn_big_p1;
        sum_add = 15'd0;
        if (sgn_big_p1 == sgn_sml_p1) begin
            sum_add = {1'b0, man_big_p1} + {1'b0, man_sml_p1};
        end else if (man_big_p1 > man_sml_p1) begin
            sum_add = {1'b0, man_big_p1 - man_sml_p1};
        end else if (man_big_p1 < man_sml_p1) begin
            sum_add = {1'b0, man_sml_p1 - man_big_p1};
            sgn_add = sgn_sml_p1;
        end else begin
            sgn_add = 1'b0;
        end
    end

    // NORM: renormalise, truncate guard bits, then classify range
    always_comb begin
        norm_lz  = 4'd0;
        norm_man = sum_p2[13:0];
        norm_exp = $signed({2'b00, exp_p2});
        norm_res = 16'h0000;
        if (sum_p2[14]) begin
            norm_man = sum_p2[14:1];
            norm_exp = $signed({2'b00, exp_p2}) + 7'sd1;
        end else begin
            for (int i = 0; i < 14; i++)
                if (sum_p2[i]) norm_lz = 4'(13 - i);
            norm_man = sum_p2[13:0] << norm_lz;
            norm_exp = $signed({2'b00, exp_p2}) - $signed({3'b000, norm_lz});
        end
        if (spc_p2)                                       norm_res = spc_val_p2;
        else if ((sum_p2 == 15'd0) || (norm_exp < 7'sd1)) norm_res = 16'h0000;
        else if (norm_exp >= 7'sd31)                      norm_res = ovf_res(sgn_p2);
        else                                              norm_res = {sgn_p2, norm_exp[4:0], norm_man[12:3]};
    end

    always_ff @(posedge i_clk) begin
        if ((state == S_IDLE) && bus.i_prod_valid) begin
            prod_p0 <= clamp_in(bus.i_prod);
            last_p0 <= bus.i_row_last;
        end
        if (state == S_ALIGN) begin
            exp_p1     <= a_big ? acc[14:10] : prod_p0[14:10];
            sgn_big_p1 <= a_big ? acc[15] : prod_p0[15];
            sgn_sml_p1 <= a_big ? prod_p0[15] : acc[15];
            man_big_p1 <= a_big ? man_a : man_b;
            man_sml_p1 <= (exp_diff >= 5'd14) ? 14'd0 : ((a_big ? man_b : man_a) >> exp_diff);
            spc_p1     <= spc[16];
            spc_val_p1 <= spc[15:0];
        end
        if (state == S_ADD) begin
            sgn_p2     <= sgn_add;
            sum_p2     <= sum_add;
            exp_p2     <= exp_p1;
            spc_p2     <= spc_p1;
            spc_val_p2 <= spc_val_p1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= S_IDLE;
            acc     <= 16'h0000;
            row_idx <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_NORM) begin
                acc <= norm_res;
            end else if ((state == S_OUT) && bus.i_row_ready) begin
                acc     <= 16'h0000;
                row_idx <= (row_idx == ROW_W'(NUM_ROWS - 1)) ? '0 : row_idx + 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt        = state;
        bus.o_prod_ready = 1'b0;
        bus.o_row_valid  = 1'b0;
        case (state)
            S_IDLE: begin
                bus.o_prod_ready = !i_rst;
                if (bus.i_prod_valid) state_nxt = S_ALIGN;
            end
            S_ALIGN: state_nxt = S_ADD;
            S_ADD:   state_nxt = S_NORM;
            S_NORM:  state_nxt = last_p0 ? S_OUT : S_IDLE;
            S_OUT: begin
                bus.o_row_valid = 1'b1;
                if (bus.i_row_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign bus.o_row_sum = acc;
    assign bus.o_row_idx = row_idx;
endmodule

// File: tb/tb_spmv_fp16_row_acc.sv
// Bench for spmv_fp16_row_acc: directed rows plus random product streams against an arithmetic FP16 model.
module tb_spmv_fp16_row_acc;
    localparam int ROW_W    = 8;
    localparam int NUM_ROWS = 4;
`ifdef SPMV_ACC_SAT_EN
    localparam logic [15:0] OVF_POS = 16'h7bff;
    localparam logic [15:0] OVF_NEG = 16'hfbff;
    localparam logic [15:0] INF_MIX = 16'h0000;
`else
    localparam logic [15:0] OVF_POS = 16'h7c00;
    localparam logic [15:0] OVF_NEG = 16'hfc00;
    localparam logic [15:0] INF_MIX = 16'h7e00;
`endif

    typedef struct {
        logic [15:0] sum;
        logic [7:0]  idx;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    int   rdy_mode = 1;
    int   vcnt = 0;
    int   obs_len = 0;
    logic [15:0] obs_sum = 16'h0;
    logic [7:0]  obs_idx = 8'h0;
    logic [15:0] m_acc = 16'h0;
    int   m_idx = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    spmv_fp16_row_acc_if #(.ROW_W(ROW_W)) bus ();
    spmv_fp16_row_acc #(.ROW_W(ROW_W), .NUM_ROWS(NUM_ROWS)) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endfunction

    // Reference: exact integer significands scaled by 8, smaller operand truncated by the exponent gap.
    function automatic logic [15:0] fp_add(input logic [15:0] a, input logic [15:0] b_raw);
        logic [15:0] b;
        int ea, eb, e;
        longint va, vb, r, mag;
        logic s;
        b = b_raw;
`ifdef SPMV_ACC_SAT_EN
        if (b[14:10] == 5'h1f) b = {b[15], 15'h7bff};
`endif
        if (a[14:10] == 5'h1f && a[9:0] != 10'd0) return a;
        if (a[14:10] == 5'h1f && b[14:10] == 5'h1f && a[15] != b[15]) return 16'h7e00;
        if (a[14:10] == 5'h1f) return a;
        if (b[14:10] == 5'h1f) return {b[15], 15'h7c00};
        ea = int'(a[14:10]);
        eb = int'(b[14:10]);
        va = (ea == 0) ? 0 : longint'(1024 + int'(a[9:0])) * 8;
        vb = (eb == 0) ? 0 : longint'(1024 + int'(b[9:0])) * 8;
        e  = (ea > eb) ? ea : eb;
        va = va >> (e - ea);
        vb = vb >> (e - eb);
        r  = (a[15] ? -va : va) + (b[15] ? -vb : vb);
        if (r == 0) return 16'h0000;
        s   = (r < 0);
        mag = s ? -r : r;
        while (mag >= 16384) begin mag = mag >> 1; e++; end
        while (mag < 8192)   begin mag = mag << 1; e--; end
        if (e < 1) return 16'h0000;
        if (e >= 31) return s ? OVF_NEG : OVF_POS;
        return {s, 5'(e), mag[12:3]};
    endfunction

    function automatic void model_push(input logic [15:0] p, input logic last);
        exp_t x;
        m_acc = fp_add(m_acc, p);
        if (last) begin
            x.sum = m_acc;
            x.idx = 8'(m_idx);
            exp_q.push_back(x);
            m_acc = 16'h0;
            m_idx = (m_idx + 1) % NUM_ROWS;
        end
    endfunction

    function automatic logic [15:0] rand_fp();
        logic [15:0] v;
        int k;
        k = $urandom_range(0, 99);
        v = {1'($urandom_range(0, 1)), 5'($urandom_range(10, 20)), 10'($urandom)};
        if (k < 6)       v[14:10] = 5'd0;
        else if (k < 8)  v[14:10] = 5'h1f;
        else if (k < 14) v[14:10] = 5'($urandom_range(27, 30));
        return v;
    endfunction

    task automatic wait_ready(input string name);
        int n = 0;
        while (bus.o_prod_ready !== 1'b1 && n < 64) begin @(negedge clk); n++; end
        if (n >= 64) begin
            total++; bad++;
            $display("FAIL %s_timeout: got ready=0 expected 1", name);
        end
    endtask

    task automatic send(input logic [15:0] p, input logic last);
        model_push(p, last);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        bus.i_prod_valid = 1'b1;
        bus.i_prod       = p;
        bus.i_row_last   = last;
        wait_ready("send");
        @(negedge clk);
        bus.i_prod_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 500) begin @(negedge clk); n++; end
        if (exp_q.size() != 0) begin
            total++; bad++;
            $display("FAIL drain_timeout: got pending=%0d expected 0", exp_q.size());
        end
    endtask

    task automatic row_chk(input string name, input logic [15:0] s, input logic [7:0] i);
        wait_drain();
        check({name, "_sum"}, 32'(obs_sum), 32'(s));
        check({name, "_idx"}, 32'(obs_idx), 32'(i));
    endtask

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       bus.i_row_ready = 1'($urandom_range(0, 1));
            1:       bus.i_row_ready = 1'b1;
            default: bus.i_row_ready = 1'b0;
        endcase
    end

    always @(negedge clk) begin
        if (rst === 1'b0 && bus.o_row_valid === 1'b1) begin
            vcnt++;
            if (exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_row: got sum=%h idx=%0d expected no row", bus.o_row_sum, bus.o_row_idx);
            end else begin
                check("row_sum", 32'(bus.o_row_sum), 32'(exp_q[0].sum));
                check("row_idx", 32'(bus.o_row_idx), 32'(exp_q[0].idx));
                check("ready_in_out", 32'(bus.o_prod_ready), 0);
                if (bus.i_row_ready === 1'b1) begin
                    obs_sum = bus.o_row_sum;
                    obs_idx = bus.o_row_idx;
                    obs_len = vcnt;
                    vcnt    = 0;
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1;
        bus.i_prod_valid = 1'b0;
        bus.i_prod       = 16'h0;
        bus.i_row_last   = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_prod_ready", 32'(bus.o_prod_ready), 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_prod_ready", 32'(bus.o_prod_ready), 1);
        check("rst_row_valid", 32'(bus.o_row_valid), 0);
        check("rst_row_sum", 32'(bus.o_row_sum), 0);
        check("rst_row_idx", 32'(bus.o_row_idx), 0);

        check("pin_one", 32'(fp_add(16'h0000, 16'h3c00)), 'h3c00);
        check("pin_two", 32'(fp_add(16'h3c00, 16'h3c00)), 'h4000);
        check("pin_cancel", 32'(fp_add(16'h3e00, 16'hbe00)), 'h0000);
        check("pin_1025", 32'(fp_add(16'h6400, 16'h3c00)), 'h6401);
        check("pin_trunc", 32'(fp_add(16'h6800, 16'h3c00)), 'h6800);
        check("pin_denorm", 32'(fp_add(16'h0000, 16'h0123)), 'h0000);
        check("pin_ovf", 32'(fp_add(16'h7bff, 16'h7bff)), 32'(OVF_POS));
        check("pin_ninf", 32'(fp_add(16'h0000, 16'hfc00)), 32'(OVF_NEG));

        rdy_mode = 1;
        send(16'h3c00, 1'b0); send(16'h3c00, 1'b1);
        row_chk("two", 16'h4000, 8'd0);
        check("valid_len", 32'(obs_len), 1);
        send(16'h3e00, 1'b0); send(16'hbe00, 1'b1);
        row_chk("cancel", 16'h0000, 8'd1);
        send(16'h4400, 1'b1);
        row_chk("single", 16'h4400, 8'd2);
        send(16'h7bff, 1'b0); send(16'h7bff, 1'b1);
        row_chk("ovf", OVF_POS, 8'd3);
        send(16'h6400, 1'b0); send(16'h3c00, 1'b1);
        row_chk("wrap_1025", 16'h6401, 8'd0);
        send(16'h6800, 1'b0); send(16'h3c00, 1'b1);
        row_chk("trunc", 16'h6800, 8'd1);
        send(16'h0123, 1'b1);
        row_chk("denorm", 16'h0000, 8'd2);
        send(16'h0000, 1'b1);
        row_chk("empty", 16'h0000, 8'd3);

        model_push(16'h3c00, 1'b0);
        model_push(16'h3c00, 1'b0);
        bus.i_prod = 16'h3c00; bus.i_row_last = 1'b0; bus.i_prod_valid = 1'b1;
        wait_ready("lat");
        @(negedge clk);
        n = 1;
        while (bus.o_prod_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        check("accept_interval", 32'(n), 4);
        @(negedge clk);
        bus.i_prod_valid = 1'b0;
        send(16'h0000, 1'b1);
        row_chk("lat_row", 16'h4000, 8'd0);

        rdy_mode = 2;
        model_push(16'h3c00, 1'b1);
        bus.i_prod = 16'h3c00; bus.i_row_last = 1'b1; bus.i_prod_valid = 1'b1;
        wait_ready("hold_a");
        @(negedge clk);
        model_push(16'h4000, 1'b1);
        bus.i_prod = 16'h4000;
        n = 0;
        while (bus.o_row_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        check("hold_reach_out", 32'(bus.o_row_valid), 1);
        repeat (5) begin
            @(negedge clk);
            check("hold_valid", 32'(bus.o_row_valid), 1);
            check("hold_sum", 32'(bus.o_row_sum), 'h3c00);
            check("hold_idx", 32'(bus.o_row_idx), 1);
            check("hold_prod_ready", 32'(bus.o_prod_ready), 0);
        end
        rdy_mode = 1;
        wait_ready("hold_b");
        @(negedge clk);
        bus.i_prod_valid = 1'b0;
        row_chk("held_prod", 16'h4000, 8'd2);

        bus.i_prod = 16'h3c00; bus.i_row_last = 1'b0; bus.i_prod_valid = 1'b1;
        wait_ready("midrst");
        @(negedge clk);
        bus.i_prod_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("midrst_prod_ready", 32'(bus.o_prod_ready), 0);
        rst = 1'b0;
        m_acc = 16'h0;
        m_idx = 0;
        exp_q.delete();
        @(negedge clk);
        check("midrst_ready", 32'(bus.o_prod_ready), 1);
        check("midrst_idx", 32'(bus.o_row_idx), 0);
        check("midrst_sum", 32'(bus.o_row_sum), 0);
        send(16'h4400, 1'b1);
        row_chk("after_rst", 16'h4400, 8'd0);

        send(16'h7c00, 1'b0); send(16'hfc00, 1'b1);
        row_chk("inf_mix", INF_MIX, 8'd1);

        rdy_mode = 0;
        for (int k = 0; k < 300; k++) send(rand_fp(), 1'($urandom_range(0, 3) == 0));
        send(16'h0000, 1'b1);
        wait_drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
